// File: rtl/bk_limb_chain_adder_pkg.sv
// Shared constants and state encoding for the limb-chained Brent-Kung add/sub engine.
package bk_limb_chain_adder_pkg;
    localparam int BK_W = 16;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_CHAIN = 1'b1
    } state_e;
endpackage

// File: rtl/bk_limb_chain_adder_bk_adder.sv
// 16-bit Brent-Kung parallel-prefix adder, purely combinational.
module BK_Adder
    import bk_limb_chain_adder_pkg::*;
(
    output logic [BK_W-1:0] s,
    output logic            cout,
    input  logic [BK_W-1:0] a,
    input  logic [BK_W-1:0] b,
    input  logic            cin
);
    logic [BK_W-1:0] g, p, gg, pp, c;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        // Fold cin into bit 0 so every group generate already includes it.
        gg[0] = g[0] | (p[0] & cin);
        // Up-sweep: build power-of-two group terms.
        for (int l = 0; l < 4; l++) begin
            for (int i = (2 << l) - 1; i < BK_W; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        // Down-sweep: fill in the remaining prefix positions.
        for (int l = 2; l >= 0; l--) begin
            for (int i = (3 << l) - 1; i < BK_W; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        c    = {gg[BK_W-2:0], cin};
        s    = p ^ c;
        cout = gg[BK_W-1];
    end
endmodule

// File: rtl/bk_limb_chain_adder.sv
// Streams multi-limb add/sub through one BK_Adder, chaining the carry between limbs.
module bk_limb_chain_adder
    import bk_limb_chain_adder_pkg::*;
#(
    parameter int LIMB_W    = 16,
    parameter int MAX_LIMBS = 4,
    parameter int IDX_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIMB_W-1:0] in_a,
    input  logic [LIMB_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_sub,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIMB_W-1:0] out_s,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_carry,
    output logic              err_len
);
    if (LIMB_W != BK_W) begin : g_bad_width
        $error("LIMB_W must equal the BK_Adder width (16)");
    end

    state_e            state_q, state_d;
    logic              carry_q, carry_d, sub_q, sub_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d, last_q, last_d, oc_q, oc_d, err_q, err_d;
    logic [LIMB_W-1:0] s_q, s_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              first, sub, cin, accept, overrun, end_op, cout;
    logic [LIMB_W-1:0] b_eff, sum;

    assign first    = (state_q == ST_FIRST);
    assign sub      = first ? in_sub : sub_q;
    assign cin      = first ? (in_sub | in_cin) : carry_q;
    assign b_eff    = sub ? ~in_b : in_b;
    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign overrun  = (cnt_q == IDX_W'(MAX_LIMBS - 1)) && !in_last;
    assign end_op   = in_last || overrun;

    BK_Adder u_add (
        .s    (sum),
        .cout (cout),
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin)
    );

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        s_d     = s_q;
        idx_d   = idx_q;
        last_d  = last_q;
        oc_d    = oc_q;
        err_d   = err_q;
        if (accept) begin
            vld_d   = 1'b1;
            s_d     = sum;
            idx_d   = cnt_q;
            last_d  = end_op;
            oc_d    = end_op ? cout : 1'b0;
            carry_d = cout;
            sub_d   = sub;
            if (overrun) err_d = 1'b1;
            if (end_op) begin
                state_d = ST_FIRST;
                cnt_d   = '0;
            end else begin
                state_d = ST_CHAIN;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FIRST;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            s_q     <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            oc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            oc_q    <= oc_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign out_s     = s_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign out_carry = oc_q;
    assign err_len   = err_q;
endmodule

// File: tb/tb_bk_limb_chain_adder.sv
// Bench for bk_limb_chain_adder: vector table plus backpressure, reset and overrun sequences.
module tb_bk_limb_chain_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_cin, in_sub, in_last;
    logic [15:0] in_a, in_b;
    logic        out_valid, out_ready, out_last, out_carry, err_len;
    logic [15:0] out_s;
    logic [1:0]  out_idx;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub, last;
        logic [15:0] s;
        logic [1:0]  idx;
        logic        xlast, xcarry;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic [1:0]  idx;
        logic        last, carry;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;

    bk_limb_chain_adder #(.LIMB_W(16), .MAX_LIMBS(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_idx(out_idx), .out_last(out_last), .out_carry(out_carry),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    // A transfer seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output s=%h idx=%0d", out_s, out_idx);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_s", 32'(out_s), 32'(e.s));
                chk("out_idx", 32'(out_idx), 32'(e.idx));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("out_carry", 32'(out_carry), 32'(e.carry));
            end
        end
    end

    function automatic exp_t to_exp(vec_t v);
        exp_t e;
        e.s = v.s; e.idx = v.idx; e.last = v.xlast; e.carry = v.xcarry;
        return e;
    endfunction

    // Called and returns at posedge+2.
    task automatic send(input vec_t v, input bit push);
        bit ok;
        ok = 1'b0;
        in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_last = v.last;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
            errors++;
            checks++;
        end
        if (push && ok) sbq.push_back(to_exp(v));
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50; n++) begin
            if (sbq.size() == 0) break;
            @(posedge clk); #2;
        end
        chk("drain_queue_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        exp_t y;
        tbl[0]  = '{16'h9999, 16'h1000, 1'b1, 1'b0, 1'b1, 16'hA99A, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 2'd1, 1'b1, 1'b0};
        tbl[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 2'd0, 1'b1, 1'b1};
        tbl[4]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002, 2'd0, 1'b1, 1'b1};
        tbl[6]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'hFFFF, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0};
        tbl[11] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0};
        tbl[12] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd3, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_s", 32'(out_s), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_err_len", 32'(err_len), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) send(tbl[i], 1'b1);
        drain();
        chk("tbl_err_len", 32'(err_len), 32'd0);

        // Backpressure: result held, input stalled, then both move together.
        out_ready = 1'b0;
        send('{16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h2345, 2'd0, 1'b1, 1'b0}, 1'b1);
        in_a = 16'h0003; in_b = 16'h0004; in_cin = 1'b0; in_sub = 1'b0; in_last = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_s", 32'(out_s), 32'h2345);
            chk("bp_out_idx", 32'(out_idx), 32'd0);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", 32'(in_ready), 32'd1);
        y.s = 16'h0007; y.idx = 2'd0; y.last = 1'b1; y.carry = 1'b0;
        sbq.push_back(y);
        @(posedge clk); #2;
        in_valid = 1'b0;
        drain();

        // Reset mid-operation discards the pending limb and the chained carry.
        out_ready = 1'b0;
        send('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0}, 1'b0);
        do_reset();
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send('{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 2'd0, 1'b1, 1'b0}, 1'b1);
        drain();

        // Length overrun: 5 limbs without last.
        for (int k = 0; k < 5; k++) begin
            v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 2'(k % 4), (k == 3), 1'b0};
            send(v, 1'b1);
            if (k == 2) chk("ovr_err_before", 32'(err_len), 32'd0);
            if (k == 3) chk("ovr_err_set", 32'(err_len), 32'd1);
        end
        send('{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 2'd1, 1'b1, 1'b0}, 1'b1);
        drain();
        chk("ovr_err_sticky", 32'(err_len), 32'd1);
        do_reset();
        chk("ovr_err_cleared", 32'(err_len), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
